victim_way_sel_d_cache: RTL
===========================

# victim_way_sel_d_cache

Replacement-victim selector for the 16-way data cache. On request it scans a snapshot of the per-way valid bits, picks up to two distinct victim ways (invalid ways first, LFSR-random otherwise), and drives them as 5-bit way codes to the valid-bit update logic. It is the producer of the `way1`/`way2` code interface consumed by the valid-bit tracker.

## Interface
- `NUM_WAYS`, 16: ways per set; fixed, other values unsupported.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, synchronous, active-low. Clock is `clk`.
- `req_valid`, in, 1: victim request.
- `req_ready`, out, 1: block idle, request accepted; combinational, equal to `state==IDLE`.
- `valid_in`, in, 16: bit i = way i valid; sampled at acceptance.
- `way1_out`, out, 5: primary victim code.
  - [4:1] = way id.
  - [0] = keep: 0 means replace/invalidate, 1 means no action.
- `way2_out`, out, 5: secondary victim code, same encoding, distinct id from `way1_out`.
- `out_valid`, out, 1: victim codes presented.
- `out_ready`, in, 1: consumer takes codes.
- `lock_in`, in, 16: only with `VICTIM_LOCK_EN`; bit i = way i must never be chosen.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `req_valid && req_ready` captures `valid_in` (and `lock_in`), clears scan index and found count, then goes to SCAN.
- SCAN:
  - One way per cycle, index 0..15 ascending.
  - Way i is a candidate if the snapshot valid bit is 0 (and, with locks, the way is not locked).
  - The first two candidates are recorded in order.
  - After index 15, outputs are resolved and the FSM goes to DONE.
- Resolution, with R = LFSR value in the cycle index 15 is scanned:
  - 2 or more found: way1 = first, way2 = second.
  - 1 found: way1 = found; way2 = R[3:0], or (R[3:0]+1) mod 16 if that equals way1.
  - 0 found: way1 = R[3:0]; way2 = R[7:4], or (R[7:4]+1) mod 16 if that equals way1.
  - Keep bits of resolved codes are 0.
- DONE:
  - `out_valid`=1; codes held stable until `out_ready`.
  - On `out_valid && out_ready`: codes revert to 5'h01, and the FSM goes to IDLE.
- Outside DONE, both codes are 5'h01 (way 0, keep=1), so the consumer takes no action.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state, including while reset is deasserted and the FSM is idle.
  - Reset loads `LFSR_SEED`.
- A request while busy is not accepted (`req_ready`=0); the requester holds.

## Timing
- Reset values:
  - state IDLE
  - `out_valid` 0
  - `way1_out`/`way2_out` 5'h01
  - `req_ready` 1
  - LFSR `LFSR_SEED`
  - scan index/count 0
- Request accepted in cycle N:
  - SCAN occupies N+1..N+16.
  - `out_valid` is high from N+17.
  - If `out_ready` is high in N+17, `req_ready` is high in N+18.
- Minimum request-to-request spacing: 18 cycles.
- All outputs except `req_ready` are registered.
- Reset mid-SCAN or mid-DONE: on the next edge, return to reset values and discard the snapshot.
- `out_ready` high outside DONE is ignored.

## Configuration
- `VICTIM_LOCK_EN` defined:
  - `lock_in` port exists; locked ways are excluded from scan candidates.
  - A random draw that lands on a locked or already-chosen way advances (+1 mod 16) to the next eligible way.
  - If no eligible way exists, that code's keep bit is 1.
  - All 16 locked gives both codes 5'h01 with `out_valid` still asserted.
- Undefined: no `lock_in` port; every way is eligible.

## Structure
- Package `d_cache_pkg`:
  - `NUM_WAYS`=16, `WAY_W`=4.
  - `way_code_t` packed struct {id[3:0], keep}.
  - FSM enum `victim_state_t`.
  - LFSR seed and tap constants.
- Sub-module `lfsr16`: enable-free free-running Galois LFSR with synchronous active-low reset to seed, output `q[15:0]`.

## Test plan
- All ways invalid (`valid_in`=16'h0000):
  - way1=5'h00 (way 0), way2=5'h02 (way 1).
  - `out_valid` rises exactly 17 cycles after acceptance.
- Single invalid way (`valid_in`=16'hFF7F, way 7):
  - way1=5'h0E.
  - way2 = reference-model LFSR pick, not 7, keep=0.
- All ways valid (16'hFFFF):
  - codes match the reference LFSR model, ids distinct, keep=0.
  - Repeated requests produce a different pair.
- Backpressure: hold `out_ready`=0 for 10 cycles.
  - Codes stable, `req_ready`=0, new `req_valid` ignored.
  - Release, then codes return to 5'h01 next cycle.
- Reset asserted in the 8th SCAN cycle:
  - Next cycle `out_valid`=0, codes 5'h01, `req_ready`=1.
  - A fresh request completes normally.
- With `VICTIM_LOCK_EN`, `valid_in`=16'h0000 and `lock_in`=16'h0003:
  - way1=5'h04 (way 2), way2=5'h06 (way 3).
  - `lock_in`=16'hFFFF gives both codes 5'h01.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared types and constants for the data-cache victim selector.
// Way codes are {id, keep}; keep=1 means the consumer leaves the way alone.
package d_cache_pkg;

    localparam int NUM_WAYS = 16;
    localparam int WAY_W    = 4;

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    // Galois right-shift form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef struct packed {
        logic [WAY_W-1:0] id;
        logic             keep;
    } way_code_t;

    typedef enum logic [1:0] {
        VS_IDLE = 2'd0,
        VS_SCAN = 2'd1,
        VS_DONE = 2'd2
    } victim_state_t;

    localparam way_code_t CODE_NOP = '{id: '0, keep: 1'b1};

    // First non-excluded way at or after start (wrapping); NOP code if all excluded.
    function automatic way_code_t pick_way(input logic [WAY_W-1:0]    start,
                                           input logic [NUM_WAYS-1:0] excl);
        way_code_t        code;
        logic [WAY_W-1:0] id;
        code = CODE_NOP;
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            id = start + WAY_W'(k);
            if (!excl[id]) begin
                code.id   = id;
                code.keep = 1'b0;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/victim_way_sel_d_cache_lfsr16.sv
// Free-running 16-bit Galois LFSR, synchronous active-low reset to SEED.
module lfsr16
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);
    import d_cache_pkg::*;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/victim_way_sel_d_cache.sv
// Victim-way selector for the 16-way data cache: invalid ways first, LFSR pick otherwise.
// Define VICTIM_LOCK_EN to add the lock_in port that excludes ways from selection.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// SCAN  | walking the valid snapshot one way per cycle
// DONE  | codes presented, waiting for out_ready
module victim_way_sel_d_cache
#(
    parameter int          NUM_WAYS  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] valid_in,
    output logic [4:0]  way1_out,
    output logic [4:0]  way2_out,
    output logic        out_valid,
    input  logic        out_ready
`ifdef VICTIM_LOCK_EN
    ,
    input  logic [15:0] lock_in
`endif
);
    import d_cache_pkg::*;

    localparam logic [1:0] IDLE = VS_IDLE;
    localparam logic [1:0] SCAN = VS_SCAN;
    localparam logic [1:0] DONE = VS_DONE;

    localparam logic [WAY_W-1:0] LAST_IDX = WAY_W'(NUM_WAYS - 1);

    logic [1:0]       state;
    logic [WAY_W-1:0] scan_idx;
    logic [1:0]       found_cnt;
    logic [WAY_W-1:0] first_id;
    logic [WAY_W-1:0] second_id;
    logic [15:0]      snap_valid;
    logic [15:0]      snap_lock;
    way_code_t        way1_q;
    way_code_t        way2_q;
    logic             out_valid_q;
    logic [15:0]      lfsr_q;
    logic             lfsr_unused;
    logic [15:0]      lock_eff;

`ifdef VICTIM_LOCK_EN
    assign lock_eff = lock_in;
`else
    assign lock_eff = 16'h0000;
`endif

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:8];

    logic             is_cand;
    logic [1:0]       cnt_next;
    logic [WAY_W-1:0] first_next;
    logic [WAY_W-1:0] second_next;
    way_code_t        res1;
    way_code_t        res2;

    always_comb begin
        is_cand     = !snap_valid[scan_idx] && !snap_lock[scan_idx];
        first_next  = first_id;
        second_next = second_id;
        cnt_next    = found_cnt;
        if (is_cand) begin
            if (found_cnt == 2'd0) begin
                first_next = scan_idx;
                cnt_next   = 2'd1;
            end else if (found_cnt == 2'd1) begin
                second_next = scan_idx;
                cnt_next    = 2'd2;
            end
        end

        // Resolution includes this cycle's candidate so index 15 counts.
        res1 = CODE_NOP;
        res2 = CODE_NOP;
        case (cnt_next)
            2'd0: begin
                res1 = pick_way(lfsr_q[3:0], snap_lock);
                res2 = pick_way(lfsr_q[7:4], snap_lock | (16'h0001 << res1.id));
            end
            2'd1: begin
                res1 = '{id: first_next, keep: 1'b0};
                res2 = pick_way(lfsr_q[3:0], snap_lock | (16'h0001 << first_next));
            end
            default: begin
                res1 = '{id: first_next,  keep: 1'b0};
                res2 = '{id: second_next, keep: 1'b0};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            scan_idx    <= '0;
            found_cnt   <= 2'd0;
            first_id    <= '0;
            second_id   <= '0;
            snap_valid  <= 16'h0000;
            snap_lock   <= 16'h0000;
            way1_q      <= CODE_NOP;
            way2_q      <= CODE_NOP;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        snap_valid <= valid_in;
                        snap_lock  <= lock_eff;
                        scan_idx   <= '0;
                        found_cnt  <= 2'd0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    scan_idx  <= scan_idx + 1'b1;
                    found_cnt <= cnt_next;
                    first_id  <= first_next;
                    second_id <= second_next;
                    if (scan_idx == LAST_IDX) begin
                        way1_q      <= res1;
                        way2_q      <= res2;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        way1_q      <= CODE_NOP;
                        way2_q      <= CODE_NOP;
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign way1_out  = way1_q;
    assign way2_out  = way2_q;
    assign out_valid = out_valid_q;

endmodule
